// File: rtl/vga_pkg.sv
// Shared VGA timing constants, region type and sync-window helpers.
// Default timing is 640x480@60 Hz with a 25 MHz pixel rate.
package vga_pkg;

  localparam int unsigned CNT_W     = 10;
  localparam int unsigned MAX_TOTAL = 1 << CNT_W;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} vga_region_t;

  // True when cnt lies in [act+fp, act+fp+syn).
  function automatic logic in_sync_window(input logic [CNT_W-1:0] cnt,
                                          input int unsigned     act,
                                          input int unsigned     fp,
                                          input int unsigned     syn);
    int unsigned c;
    c = 32'(cnt);
    return (c >= act + fp) && (c < act + fp + syn);
  endfunction

  // Every region must be non-empty and the axis must fit the counter width.
  function automatic bit timing_ok(input int unsigned act, input int unsigned fp,
                                   input int unsigned syn, input int unsigned bp);
    return (act >= 1) && (fp >= 1) && (syn >= 1) && (bp >= 1) &&
           (act + fp + syn + bp <= MAX_TOTAL);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One VGA axis: wrapping position counter with an ACTIVE/FP/SYNC/BP region FSM.
// Decoded outputs are registered from the next count so they track the count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned P_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned P_FP     = DEF_H_FP,
  parameter int unsigned P_SYNC   = DEF_H_SYNC,
  parameter int unsigned P_BP     = DEF_H_BP
) (
  input  logic             clk,
  input  logic             boton_rst,
  input  logic             step,
  output logic [CNT_W-1:0] count,
  output vga_region_t      region,
  output logic             sync,
  output logic             active,
  output logic             wrap
);

  localparam int unsigned TOTAL = P_ACTIVE + P_FP + P_SYNC + P_BP;

  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] END_ACTIVE = CNT_W'(P_ACTIVE - 1);
  localparam logic [CNT_W-1:0] END_FP     = CNT_W'(P_ACTIVE + P_FP - 1);
  localparam logic [CNT_W-1:0] END_SYNC   = CNT_W'(P_ACTIVE + P_FP + P_SYNC - 1);

  if (!timing_ok(P_ACTIVE, P_FP, P_SYNC, P_BP)) begin : g_bad_timing
    $error("vga_axis_counter: each region must be >= 1 and the total <= 1024");
  end

  logic [CNT_W-1:0] r_count, w_count_next;
  vga_region_t      r_region, w_region_next;
  logic             r_sync;
  logic             w_wrap;

  assign w_wrap = (r_count == LAST_CNT);

  always_comb begin
    w_count_next  = r_count;
    w_region_next = r_region;
    if (step) begin
      w_count_next = w_wrap ? '0 : r_count + 1'b1;
      case (r_region)
        ACTIVE:  if (r_count == END_ACTIVE) w_region_next = FP;
        FP:      if (r_count == END_FP)     w_region_next = SYNC;
        SYNC:    if (r_count == END_SYNC)   w_region_next = BP;
        BP:      if (w_wrap)                w_region_next = ACTIVE;
        default: w_region_next = ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge boton_rst) begin
    if (!boton_rst) begin
      r_count  <= '0;
      r_region <= ACTIVE;
      r_sync   <= 1'b0;
    end else begin
      r_count  <= w_count_next;
      r_region <= w_region_next;
      r_sync   <= in_sync_window(w_count_next, P_ACTIVE, P_FP, P_SYNC);
    end
  end

  assign count  = r_count;
  assign region = r_region;
  assign sync   = r_sync;
  assign active = (r_region == ACTIVE);
  assign wrap   = w_wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: divides clk by two to a pixel strobe and produces
// pixel coordinates, syncs, blanking and frame markers for the DAC.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        SYNC_ACT = 1'b0
) (
  input  logic             clk,
  input  logic             boton_rst,
  output logic [CNT_W-1:0] cuentaX,
  output logic [CNT_W-1:0] cuentaY,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic             vga_blank_n,
  output logic             vga_sync_n,
  output logic             vga_clk,
  output logic             pixel_en,
  output logic             frame_start,
  output logic             vblank
);

  logic        r_div, r_frame_start;
  logic        w_h_wrap, w_v_wrap, w_v_step;
  logic        w_h_sync, w_v_sync, w_h_active, w_v_active;
  vga_region_t w_h_region, w_v_region;
  logic        w_unused_region;

  // Counters move on the edge where r_div is 1, so vga_clk rises mid-pixel.
  always_ff @(posedge clk or negedge boton_rst) begin
    if (!boton_rst) begin
      r_div         <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= ~r_div;
      r_frame_start <= r_div & w_h_wrap & w_v_wrap;
    end
  end

  assign w_v_step = r_div & w_h_wrap;

  vga_axis_counter #(
    .P_ACTIVE (H_ACTIVE),
    .P_FP     (H_FP),
    .P_SYNC   (H_SYNC),
    .P_BP     (H_BP)
  ) u_h_axis (
    .clk       (clk),
    .boton_rst (boton_rst),
    .step      (r_div),
    .count     (cuentaX),
    .region    (w_h_region),
    .sync      (w_h_sync),
    .active    (w_h_active),
    .wrap      (w_h_wrap)
  );

  vga_axis_counter #(
    .P_ACTIVE (V_ACTIVE),
    .P_FP     (V_FP),
    .P_SYNC   (V_SYNC),
    .P_BP     (V_BP)
  ) u_v_axis (
    .clk       (clk),
    .boton_rst (boton_rst),
    .step      (w_v_step),
    .count     (cuentaY),
    .region    (w_v_region),
    .sync      (w_v_sync),
    .active    (w_v_active),
    .wrap      (w_v_wrap)
  );

  assign w_unused_region = ^{w_h_region, w_v_region};

  assign pixel_en    = r_div;
  assign vga_clk     = r_div;
  assign vga_sync_n  = 1'b0;
  assign vga_hsync   = w_h_sync ? SYNC_ACT : ~SYNC_ACT;
  assign vga_vsync   = w_v_sync ? SYNC_ACT : ~SYNC_ACT;
  assign vga_blank_n = w_h_active & w_v_active;
  assign vblank      = ~w_v_active;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a tiny 14x7 instance,
// checked by a per-clk scoreboard, position tables and sequence checks.
module tb_vga_timing_gen;

  logic clk   = 1'b0;
  logic rst_d = 1'b0;
  logic rst_s = 1'b0;

  always #5 clk = ~clk;

  logic [9:0] d_x, d_y, s_x, s_y;
  logic d_hs, d_vs, d_bn, d_sn, d_ck, d_pe, d_fs, d_vb;
  logic s_hs, s_vs, s_bn, s_sn, s_ck, s_pe, s_fs, s_vb;

  vga_timing_gen u_dut_d (
    .clk         (clk),
    .boton_rst   (rst_d),
    .cuentaX     (d_x),
    .cuentaY     (d_y),
    .vga_hsync   (d_hs),
    .vga_vsync   (d_vs),
    .vga_blank_n (d_bn),
    .vga_sync_n  (d_sn),
    .vga_clk     (d_ck),
    .pixel_en    (d_pe),
    .frame_start (d_fs),
    .vblank      (d_vb)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1)
  ) u_dut_s (
    .clk         (clk),
    .boton_rst   (rst_s),
    .cuentaX     (s_x),
    .cuentaY     (s_y),
    .vga_hsync   (s_hs),
    .vga_vsync   (s_vs),
    .vga_blank_n (s_bn),
    .vga_sync_n  (s_sn),
    .vga_clk     (s_ck),
    .pixel_en    (s_pe),
    .frame_start (s_fs),
    .vblank      (s_vb)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic hs, vs, bn, vb, fs, pe, ck, sn;
  } obs_t;

  // flags = {hsync, vsync, blank_n, vblank, frame_start, pixel_en}
  typedef struct {
    int         edges;
    int         x;
    int         y;
    logic [5:0] flags;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t decode(input int x, input int y, input int ha, input int hf,
                                  input int hw, input int va, input int vf, input int vw,
                                  input logic div, input logic fs);
    obs_t o;
    o.x  = 10'(x);
    o.y  = 10'(y);
    o.hs = !((x >= ha + hf) && (x < ha + hf + hw));
    o.vs = !((y >= va + vf) && (y < va + vf + vw));
    o.bn = (x < ha) && (y < va);
    o.vb = (y >= va);
    o.fs = fs;
    o.pe = div;
    o.ck = div;
    o.sn = 1'b0;
    return o;
  endfunction

  function automatic obs_t obs_d();
    return {d_x, d_y, d_hs, d_vs, d_bn, d_vb, d_fs, d_pe, d_ck, d_sn};
  endfunction

  function automatic obs_t obs_s();
    return {s_x, s_y, s_hs, s_vs, s_bn, s_vb, s_fs, s_pe, s_ck, s_sn};
  endfunction

  function automatic vec_t mk(input int e, input int x, input int y, input logic [5:0] f);
    vec_t v;
    v.edges = e;
    v.x     = x;
    v.y     = y;
    v.flags = f;
    return v;
  endfunction

  // Reference models: push the expected outputs after every clk or reset event.
  int   md_x = 0, md_y = 0, ms_x = 0, ms_y = 0;
  logic md_div = 1'b0, md_fs = 1'b0, ms_div = 1'b0, ms_fs = 1'b0;
  obs_t q_d[$];
  obs_t q_s[$];

  initial forever begin
    @(posedge clk or negedge rst_d);
    if (!rst_d) begin
      md_x = 0; md_y = 0; md_div = 1'b0; md_fs = 1'b0;
      q_d.delete();
    end else begin
      md_fs = md_div && (md_x == 799) && (md_y == 524);
      if (md_div) begin
        if (md_x == 799) begin
          md_x = 0;
          md_y = (md_y == 524) ? 0 : md_y + 1;
        end else begin
          md_x++;
        end
      end
      md_div = !md_div;
    end
    q_d.push_back(decode(md_x, md_y, 640, 16, 96, 480, 10, 2, md_div, md_fs));
  end

  initial forever begin
    @(posedge clk or negedge rst_s);
    if (!rst_s) begin
      ms_x = 0; ms_y = 0; ms_div = 1'b0; ms_fs = 1'b0;
      q_s.delete();
    end else begin
      ms_fs = ms_div && (ms_x == 13) && (ms_y == 6);
      if (ms_div) begin
        if (ms_x == 13) begin
          ms_x = 0;
          ms_y = (ms_y == 6) ? 0 : ms_y + 1;
        end else begin
          ms_x++;
        end
      end
      ms_div = !ms_div;
    end
    q_s.push_back(decode(ms_x, ms_y, 8, 2, 2, 4, 1, 1, ms_div, ms_fs));
  end

  initial forever begin
    @(negedge clk);
    while (q_d.size() > 1) void'(q_d.pop_front());
    while (q_s.size() > 1) void'(q_s.pop_front());
    if (q_d.size() == 1) check("sb_default", 64'(obs_d()), 64'(q_d.pop_front()));
    if (q_s.size() == 1) check("sb_small", 64'(obs_s()), 64'(q_s.pop_front()));
  end

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected test completion");
    finish_test();
  end

  vec_t tab_d[9];
  vec_t tab_s[11];
  obs_t rst_obs;

  initial begin
    int   e;
    int   fall1, fall2, lowlen, run, cnt, pulses;
    logic prev;

    rst_obs = decode(0, 0, 8, 2, 2, 4, 1, 1, 1'b0, 1'b0);

    tab_d[0] = mk(1,    0,   0, 6'b111001);
    tab_d[1] = mk(2,    1,   0, 6'b111000);
    tab_d[2] = mk(1280, 640, 0, 6'b110000);
    tab_d[3] = mk(1312, 656, 0, 6'b010000);
    tab_d[4] = mk(1502, 751, 0, 6'b010000);
    tab_d[5] = mk(1504, 752, 0, 6'b110000);
    tab_d[6] = mk(1598, 799, 0, 6'b110000);
    tab_d[7] = mk(1600, 0,   1, 6'b111000);
    tab_d[8] = mk(1602, 1,   1, 6'b111000);

    tab_s[0]  = mk(16,  8,  0, 6'b110000);
    tab_s[1]  = mk(20,  10, 0, 6'b010000);
    tab_s[2]  = mk(22,  11, 0, 6'b010000);
    tab_s[3]  = mk(24,  12, 0, 6'b110000);
    tab_s[4]  = mk(28,  0,  1, 6'b111000);
    tab_s[5]  = mk(112, 0,  4, 6'b110100);
    tab_s[6]  = mk(140, 0,  5, 6'b100100);
    tab_s[7]  = mk(168, 0,  6, 6'b110100);
    tab_s[8]  = mk(194, 13, 6, 6'b110100);
    tab_s[9]  = mk(196, 0,  0, 6'b111010);
    tab_s[10] = mk(198, 1,  0, 6'b111000);

    repeat (3) @(posedge clk);
    #1;
    check("reset_state_default", 64'(obs_d()), 64'(rst_obs));
    check("reset_state_small", 64'(obs_s()), 64'(rst_obs));

    // Default instance: release, then position table.
    @(posedge clk);
    #2 rst_d = 1'b1;
    e = 0;
    for (int i = 0; i < 9; i++) begin
      repeat (tab_d[i].edges - e) @(posedge clk);
      #1;
      e = tab_d[i].edges;
      check($sformatf("tab_d[%0d]", i), {d_x, d_y, d_hs, d_vs, d_bn, d_vb, d_fs, d_pe},
            {10'(tab_d[i].x), 10'(tab_d[i].y), tab_d[i].flags});
    end

    // Asynchronous reset mid-line at (700,1).
    repeat (3000 - e) @(posedge clk);
    #1;
    check("pre_reset_pos", {d_x, d_y}, {10'd700, 10'd1});
    #1 rst_d = 1'b0;
    #1;
    check("async_reset_default", 64'(obs_d()), 64'(rst_obs));
    repeat (2) @(posedge clk);
    #2 rst_d = 1'b1;

    // First hsync pulse after release must be complete; period one line.
    fall1 = -1; fall2 = -1; lowlen = -1; run = 0; prev = 1'b1;
    for (int i = 1; i <= 4000 && fall2 < 0; i++) begin
      @(posedge clk);
      #1;
      if (prev && !d_hs) begin
        if (fall1 < 0) fall1 = i;
        else fall2 = i;
      end
      if (!d_hs) run++;
      else if (!prev && lowlen < 0) lowlen = run;
      prev = d_hs;
    end
    check("hsync_first_fall", 64'(fall1), 64'(1312));
    check("hsync_low_clks", 64'(lowlen), 64'(192));
    check("hsync_period", 64'(fall2 - fall1), 64'(1600));

    // Small instance: release, then position table.
    @(posedge clk);
    #2 rst_s = 1'b1;
    e = 0;
    for (int i = 0; i < 11; i++) begin
      repeat (tab_s[i].edges - e) @(posedge clk);
      #1;
      e = tab_s[i].edges;
      check($sformatf("tab_s[%0d]", i), {s_x, s_y, s_hs, s_vs, s_bn, s_vb, s_fs, s_pe},
            {10'(tab_s[i].x), 10'(tab_s[i].y), tab_s[i].flags});
    end

    cnt = 0;
    for (int i = 0; i < 392; i++) begin
      @(posedge clk);
      #1;
      if (s_fs) cnt++;
    end
    check("frame_start_count", 64'(cnt), 64'(2));

    fall1 = -1; fall2 = -1; lowlen = -1; run = 0; prev = 1'b1;
    for (int i = 1; i <= 600 && fall2 < 0; i++) begin
      @(posedge clk);
      #1;
      if (prev && !s_vs) begin
        if (fall1 < 0) fall1 = i;
        else fall2 = i;
      end
      if (!s_vs) run++;
      else if (!prev && lowlen < 0) lowlen = run;
      prev = s_vs;
    end
    check("vsync_period", 64'(fall2 - fall1), 64'(196));
    check("vsync_low_clks", 64'(lowlen), 64'(28));

    // Asynchronous reset mid-frame, then one clean frame.
    repeat (50) @(posedge clk);
    #2 rst_s = 1'b0;
    #1;
    check("async_reset_small", 64'(obs_s()), 64'(rst_obs));
    repeat (3) @(posedge clk);
    #2 rst_s = 1'b1;
    run = 0; pulses = 0; prev = 1'b1;
    for (int i = 1; i <= 196; i++) begin
      @(posedge clk);
      #1;
      if (!s_hs) run++;
      else if (!prev) begin
        pulses++;
        check($sformatf("hsync_width_small[%0d]", pulses), 64'(run), 64'(4));
        run = 0;
      end
      prev = s_hs;
    end
    check("hsync_pulses_small", 64'(pulses), 64'(7));
    check("frame_end_pos_small", {s_x, s_y}, {10'd0, 10'd0});

    finish_test();
  end

endmodule
